scr1_pipe_mprf_wrsched: RTL and testbench

Write-port scheduler for the multi-port register file (MPRF). Two producers share the single MPRF write port: the single-cycle ALU result path and the long-latency LSU load-return path. The block arbitrates between them round-robin and registers the winning write toward the MPRF. It also keeps a per-register busy scoreboard for outstanding loads, so the EXU can stall on read-after-write and write-after-write hazards. It sits between the EXU/LSU writeback logic and the MPRF write port.

---
 rtl/scr1_pipe_mprf_wrsched.sv | 128 ++++++++++++
 tb/tb_scr1_pipe_mprf_wrsched.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_pipe_mprf_wrsched.sv
// MPRF write-port scheduler: round-robin arbitration between the ALU result
// path and the LSU load-return path, a registered write stage toward the MPRF,
// and a per-register busy scoreboard for outstanding loads.
module scr1_pipe_mprf_wrsched #(
  parameter int ADDR_WIDTH = 5,
  parameter int XLEN       = 32,
  parameter int MAX_OUTST  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_wr_vld,
  output logic                  alu_wr_rdy,
  input  logic [ADDR_WIDTH-1:0] alu_wr_addr,
  input  logic [XLEN-1:0]       alu_wr_data,
  input  logic                  lsu_iss_vld,
  output logic                  lsu_iss_rdy,
  input  logic [ADDR_WIDTH-1:0] lsu_iss_addr,
  input  logic                  lsu_wr_vld,
  output logic                  lsu_wr_rdy,
  input  logic [ADDR_WIDTH-1:0] lsu_wr_addr,
  input  logic [XLEN-1:0]       lsu_wr_data,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic                  rs1_hzd,
  output logic                  rs2_hzd,
  output logic [1:0]            lsu_outst_cnt,
  output logic                  mprf_w_req,
  output logic [ADDR_WIDTH-1:0] mprf_rd_addr,
  output logic [XLEN-1:0]       mprf_rd_data
);

  localparam int         NREGS     = 2 ** ADDR_WIDTH;
  localparam logic [1:0] OUTST_MAX = 2'(MAX_OUTST);

  typedef enum logic {
    RR_ALU = 1'b0,
    RR_LSU = 1'b1
  } rr_e;

  logic [NREGS-1:0]      busy;
  rr_e                   rr_ptr;
  logic [1:0]            outst;
  logic                  alu_elig;
  logic                  lsu_elig;
  logic                  alu_gnt;
  logic                  lsu_gnt;
  logic                  iss_acc;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic [XLEN-1:0]       gnt_data;

  // Eligibility and round-robin grant; everything is held off during reset
  always_comb begin
    alu_elig = ~rst & alu_wr_vld & ~busy[alu_wr_addr];
    lsu_elig = ~rst & lsu_wr_vld;
    alu_gnt  = alu_elig & (~lsu_elig | (rr_ptr == RR_ALU));
    lsu_gnt  = lsu_elig & (~alu_elig | (rr_ptr == RR_LSU));
    gnt_addr = lsu_gnt ? lsu_wr_addr : alu_wr_addr;
    gnt_data = lsu_gnt ? lsu_wr_data : alu_wr_data;
  end

  assign alu_wr_rdy    = alu_gnt;
  assign lsu_wr_rdy    = lsu_gnt;
  assign lsu_iss_rdy   = ~rst & ~busy[lsu_iss_addr] & (outst < OUTST_MAX);
  assign iss_acc       = lsu_iss_vld & lsu_iss_rdy;
  assign lsu_outst_cnt = outst;

  // Source hazards: pending load, or a staged write not yet in the MPRF
  assign rs1_hzd = (rs1_addr != '0) &
                   (busy[rs1_addr] | (mprf_w_req & (mprf_rd_addr == rs1_addr)));
  assign rs2_hzd = (rs2_addr != '0) &
                   (busy[rs2_addr] | (mprf_w_req & (mprf_rd_addr == rs2_addr)));

  // Round-robin pointer flips only when both requesters were eligible
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= RR_ALU;
    end else if (alu_elig & lsu_elig) begin
      rr_ptr <= (rr_ptr == RR_ALU) ? RR_LSU : RR_ALU;
    end
  end

  // Registered write stage toward the MPRF; x0 writes are accepted but dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      mprf_w_req   <= 1'b0;
      mprf_rd_addr <= '0;
      mprf_rd_data <= '0;
    end else begin
      mprf_w_req <= (alu_gnt | lsu_gnt) & (gnt_addr != '0);
      if (alu_gnt | lsu_gnt) begin
        mprf_rd_addr <= gnt_addr;
        mprf_rd_data <= gnt_data;
      end
    end
  end

  // Busy scoreboard: the set is written last so it wins over a same-address clear
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (lsu_gnt) begin
        busy[lsu_wr_addr] <= 1'b0;
      end
      if (iss_acc && (lsu_iss_addr != '0)) begin
        busy[lsu_iss_addr] <= 1'b1;
      end
    end
  end

  // Outstanding-load counter, saturating at zero on an unexpected return
  always_ff @(posedge clk) begin
    if (rst) begin
      outst <= '0;
    end else begin
      case ({iss_acc, lsu_gnt})
        2'b10:   outst <= outst + 2'd1;
        2'b01:   if (outst != '0) outst <= outst - 2'd1;
        default: outst <= outst;
      endcase
    end
  end

  // Simulation-only guard against returns nobody is waiting for
  a_legal_return: assert property (@(posedge clk) disable iff (rst)
    lsu_gnt |-> ((outst != '0) && ((lsu_wr_addr == '0) || busy[lsu_wr_addr])));

endmodule

// File: tb/tb_scr1_pipe_mprf_wrsched.sv
// Directed bench for scr1_pipe_mprf_wrsched: per-cycle stimulus/response table
// plus hand-written contention and reset-mid-flight sequences.
module tb_scr1_pipe_mprf_wrsched;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_wr_vld, alu_wr_rdy;
  logic [4:0]  alu_wr_addr;
  logic [31:0] alu_wr_data;
  logic        lsu_iss_vld, lsu_iss_rdy;
  logic [4:0]  lsu_iss_addr;
  logic        lsu_wr_vld, lsu_wr_rdy;
  logic [4:0]  lsu_wr_addr;
  logic [31:0] lsu_wr_data;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_hzd, rs2_hzd;
  logic [1:0]  lsu_outst_cnt;
  logic        mprf_w_req;
  logic [4:0]  mprf_rd_addr;
  logic [31:0] mprf_rd_data;

  int n_vec = 0;
  int n_err = 0;

  scr1_pipe_mprf_wrsched #(.ADDR_WIDTH(5), .XLEN(32), .MAX_OUTST(2)) dut (
    .clk(clk), .rst(rst),
    .alu_wr_vld(alu_wr_vld), .alu_wr_rdy(alu_wr_rdy),
    .alu_wr_addr(alu_wr_addr), .alu_wr_data(alu_wr_data),
    .lsu_iss_vld(lsu_iss_vld), .lsu_iss_rdy(lsu_iss_rdy), .lsu_iss_addr(lsu_iss_addr),
    .lsu_wr_vld(lsu_wr_vld), .lsu_wr_rdy(lsu_wr_rdy),
    .lsu_wr_addr(lsu_wr_addr), .lsu_wr_data(lsu_wr_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_hzd(rs1_hzd), .rs2_hzd(rs2_hzd),
    .lsu_outst_cnt(lsu_outst_cnt),
    .mprf_w_req(mprf_w_req), .mprf_rd_addr(mprf_rd_addr), .mprf_rd_data(mprf_rd_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        iv;
    logic [4:0]  ia;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic [4:0]  r1;
    logic [4:0]  r2;
  } stim_t;

  typedef struct packed {
    logic        ardy;
    logic        lrdy;
    logic        irdy;
    logic        h1;
    logic        h2;
    logic [1:0]  cnt;
    logic        wreq;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } resp_t;

  typedef struct {
    string name;
    stim_t s;
    resp_t e;
  } vec_t;

  vec_t vecs[$];

  function automatic stim_t st(int r, int av, int aa, int unsigned ad, int iv, int ia,
                               int lv, int la, int unsigned ld, int r1, int r2);
    stim_t s;
    s.rst = 1'(r);  s.av = 1'(av); s.aa = 5'(aa); s.ad = ad;
    s.iv  = 1'(iv); s.ia = 5'(ia);
    s.lv  = 1'(lv); s.la = 5'(la); s.ld = ld;
    s.r1  = 5'(r1); s.r2 = 5'(r2);
    return s;
  endfunction

  function automatic resp_t ex(int ardy, int lrdy, int irdy, int h1, int h2, int cnt,
                               int wreq, int waddr, int unsigned wdata);
    resp_t e;
    e.ardy = 1'(ardy); e.lrdy = 1'(lrdy); e.irdy = 1'(irdy);
    e.h1   = 1'(h1);   e.h2   = 1'(h2);   e.cnt  = 2'(cnt);
    e.wreq = 1'(wreq); e.waddr = 5'(waddr); e.wdata = wdata;
    return e;
  endfunction

  task automatic add(string n, stim_t s, resp_t e);
    vec_t v;
    v.name = n; v.s = s; v.e = e;
    vecs.push_back(v);
  endtask

  task automatic drive(stim_t s);
    rst          = s.rst;
    alu_wr_vld   = s.av; alu_wr_addr = s.aa; alu_wr_data = s.ad;
    lsu_iss_vld  = s.iv; lsu_iss_addr = s.ia;
    lsu_wr_vld   = s.lv; lsu_wr_addr = s.la; lsu_wr_data = s.ld;
    rs1_addr     = s.r1; rs2_addr = s.r2;
  endtask

  function automatic resp_t sample();
    resp_t a;
    a.ardy = alu_wr_rdy; a.lrdy = lsu_wr_rdy; a.irdy = lsu_iss_rdy;
    a.h1 = rs1_hzd; a.h2 = rs2_hzd; a.cnt = lsu_outst_cnt;
    a.wreq = mprf_w_req; a.waddr = mprf_rd_addr; a.wdata = mprf_rd_data;
    return a;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //   name                 rst av aa ad           iv ia lv la ld           r1 r2
    //                        ardy lrdy irdy h1 h2 cnt wreq waddr wdata
    add("rst_cyc0",       st(1, 1, 5, 32'hA5A5A5A5, 1, 1, 1, 2, 32'h11111111, 5, 1),
                          ex(0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
    add("rst_cyc1",       st(1, 1, 5, 32'hA5A5A5A5, 1, 1, 1, 2, 32'h11111111, 5, 1),
                          ex(0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
    add("alu_x5",         st(0, 1, 5, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 0, 0),
                          ex(1, 0, 1, 0, 0, 0, 0, 0, 32'h0));
    add("x5_staged",      st(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0),
                          ex(0, 0, 1, 1, 0, 0, 1, 5, 32'hA5A5A5A5));
    add("iss_x7",         st(0, 0, 0, 0, 1, 7, 0, 0, 0, 7, 0),
                          ex(0, 0, 1, 0, 0, 0, 0, 5, 32'hA5A5A5A5));
    add("alu_x7_blk0",    st(0, 1, 7, 32'h77777777, 0, 7, 0, 0, 0, 7, 0),
                          ex(0, 0, 0, 1, 0, 1, 0, 5, 32'hA5A5A5A5));
    add("alu_x7_blk1",    st(0, 1, 7, 32'h77777777, 0, 7, 0, 0, 0, 7, 0),
                          ex(0, 0, 0, 1, 0, 1, 0, 5, 32'hA5A5A5A5));
    add("ret_x7",         st(0, 1, 7, 32'h77777777, 0, 7, 1, 7, 32'hDEADBEEF, 7, 0),
                          ex(0, 1, 0, 1, 0, 1, 0, 5, 32'hA5A5A5A5));
    add("alu_x7_gnt",     st(0, 1, 7, 32'h77777777, 0, 7, 0, 0, 0, 7, 0),
                          ex(1, 0, 1, 1, 0, 0, 1, 7, 32'hDEADBEEF));
    add("x7_alu_staged",  st(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0),
                          ex(0, 0, 1, 1, 0, 0, 1, 7, 32'h77777777));
    add("x7_clear",       st(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0),
                          ex(0, 0, 1, 0, 0, 0, 0, 7, 32'h77777777));
    add("iss_x1",         st(0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 2),
                          ex(0, 0, 1, 0, 0, 0, 0, 7, 32'h77777777));
    add("iss_x2",         st(0, 0, 0, 0, 1, 2, 0, 0, 0, 1, 2),
                          ex(0, 0, 1, 1, 0, 1, 0, 7, 32'h77777777));
    add("iss_x3_full",    st(0, 0, 0, 0, 1, 3, 0, 0, 0, 1, 2),
                          ex(0, 0, 0, 1, 1, 2, 0, 7, 32'h77777777));
    add("full_ret_x1",    st(0, 0, 0, 0, 1, 9, 1, 1, 32'h11111111, 1, 9),
                          ex(0, 1, 0, 1, 0, 2, 0, 7, 32'h77777777));
    add("ret_x2_iss_x9",  st(0, 0, 0, 0, 1, 9, 1, 2, 32'h22222222, 2, 9),
                          ex(0, 1, 1, 1, 0, 1, 1, 1, 32'h11111111));
    add("cnt_held",       st(0, 0, 0, 0, 0, 9, 0, 0, 0, 2, 9),
                          ex(0, 0, 0, 1, 1, 1, 1, 2, 32'h22222222));
    add("ret_x9",         st(0, 0, 0, 0, 0, 0, 1, 9, 32'h99999999, 2, 9),
                          ex(0, 1, 1, 0, 1, 1, 0, 2, 32'h22222222));
    add("alu_iss_x0",     st(0, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0, 9),
                          ex(1, 0, 1, 0, 1, 0, 1, 9, 32'h99999999));
    add("x0_dropped",     st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                          ex(0, 0, 1, 0, 0, 1, 0, 0, 32'hFFFFFFFF));
    add("ret_x0",         st(0, 0, 0, 0, 0, 0, 1, 0, 32'h12345678, 0, 0),
                          ex(0, 1, 1, 0, 0, 1, 0, 0, 32'hFFFFFFFF));
    add("x0_done",        st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                          ex(0, 0, 1, 0, 0, 0, 0, 0, 32'h12345678));

    // Bring state out of X before the first checked cycle
    drive(vecs[0].s);
    next_cycle();

    foreach (vecs[i]) begin
      drive(vecs[i].s);
      @(negedge clk);
      check(vecs[i].name, 64'(sample()), 64'(vecs[i].e));
      next_cycle();
    end

    // Contention: ALU to x3 against returns to x4 then x5
    begin
      logic [1:0]  exp_rdy [4];
      logic [4:0]  exp_addr[4];
      logic [31:0] exp_data[4];
      logic [4:0]  lsu_addrs[2];
      logic [31:0] lsu_datas[2];
      int          alu_n;
      int          lsu_n;
      exp_rdy  = '{2'b10, 2'b01, 2'b10, 2'b01};
      exp_addr = '{5'd3, 5'd4, 5'd3, 5'd5};
      exp_data = '{32'h300, 32'h400, 32'h301, 32'h500};
      lsu_addrs = '{5'd4, 5'd5};
      lsu_datas = '{32'h400, 32'h500};
      alu_n = 0;
      lsu_n = 0;

      drive(st(0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0));
      next_cycle();
      drive(st(0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0));
      @(negedge clk);
      check("pre_iss_x5_rdy", 64'(lsu_iss_rdy), 64'd1);
      next_cycle();

      for (int k = 0; k < 4; k++) begin
        drive(st(0, 1, 3, 32'h300 + alu_n, 0, 0, 1, int'(lsu_addrs[lsu_n]),
                 lsu_datas[lsu_n], 0, 0));
        @(negedge clk);
        check($sformatf("rr_rdy_%0d", k), 64'({alu_wr_rdy, lsu_wr_rdy}), 64'(exp_rdy[k]));
        if (k > 0)
          check($sformatf("rr_stage_%0d", k - 1),
                64'({mprf_w_req, mprf_rd_addr, mprf_rd_data}),
                64'({1'b1, exp_addr[k-1], exp_data[k-1]}));
        if (exp_rdy[k][1]) alu_n++;
        if (exp_rdy[k][0] && lsu_n < 1) lsu_n++;
        next_cycle();
      end
      drive(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      check("rr_stage_3", 64'({mprf_w_req, mprf_rd_addr, mprf_rd_data}),
            64'({1'b1, exp_addr[3], exp_data[3]}));
      check("rr_outst_drained", 64'(lsu_outst_cnt), 64'd0);
      next_cycle();
    end

    // Reset while a load to x6 is pending and a write to x8 is staged
    drive(st(0, 0, 0, 0, 1, 6, 0, 0, 0, 6, 8));
    next_cycle();
    drive(st(0, 1, 8, 32'h88888888, 0, 0, 0, 0, 0, 6, 8));
    @(negedge clk);
    check("mid_busy_x6", 64'({rs1_hzd, alu_wr_rdy, lsu_outst_cnt}), 64'({1'b1, 1'b1, 2'd1}));
    next_cycle();
    drive(st(1, 1, 8, 32'h88888888, 1, 10, 0, 0, 0, 6, 8));
    @(negedge clk);
    check("mid_rst_forced", 64'({alu_wr_rdy, lsu_iss_rdy, mprf_w_req, mprf_rd_addr}),
          64'({1'b0, 1'b0, 1'b1, 5'd8}));
    next_cycle();
    drive(st(0, 0, 0, 0, 0, 6, 0, 0, 0, 6, 8));
    @(negedge clk);
    check("mid_rst_after", 64'(sample()), 64'(ex(0, 0, 1, 0, 0, 0, 0, 0, 32'h0)));
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
